// File: rtl/adma_event_ack.sv
// adma_event_ack: fixed-priority event acknowledge engine with ADMA address pointer
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req[N_EVT]                      level event requests (4-phase)
//   cfg_we, delay_cfg               load new ack delay
//   addr_load, start_addr           load descriptor address pointer
//   ack[N_EVT]                      one-hot acknowledge
//   Initial_ADMA_System_Address     current descriptor address
//   busy, grant_id                  engine active / granted channel
//   abort_cnt                       saturating count of withdrawn requests
module adma_event_ack #(
    parameter int N_EVT     = 4,
    parameter int ADDR_W    = 64,
    parameter int DLY_W     = 8,
    parameter int ACK_DELAY = 4,
    parameter int ACK_HOLD  = 2,
    parameter int ADDR_CH   = 3,
    parameter int ADDR_STEP = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_EVT-1:0]         req,
    input  logic                     cfg_we,
    input  logic [DLY_W-1:0]         delay_cfg,
    input  logic                     addr_load,
    input  logic [ADDR_W-1:0]        start_addr,
    output logic [N_EVT-1:0]         ack,
    output logic [ADDR_W-1:0]        Initial_ADMA_System_Address,
    output logic                     busy,
    output logic [$clog2(N_EVT)-1:0] grant_id,
    output logic [7:0]               abort_cnt
);
    localparam int GW = $clog2(N_EVT);
    localparam int HW = $clog2(ACK_HOLD + 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;
    state_t           state, state_nxt;
    logic [DLY_W-1:0] delay_reg, cnt;
    logic [HW-1:0]    hold;
    logic [GW-1:0]    pick;
    logic             fire;
    always_comb begin
        pick = '0;
        for (int i = N_EVT - 1; i >= 0; i--)
            if (req[i]) pick = GW'(i);
    end
    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_nxt;
    // Withdrawal in WAIT is checked before the delay expiring, so a request
    // dropped on the final WAIT cycle is an abort, not an ack.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (|req) state_nxt = S_WAIT;
            S_WAIT:    state_nxt = !req[grant_id] ? S_IDLE : (cnt == '0) ? S_ACK : S_WAIT;
            S_ACK:     if (hold == '0) state_nxt = S_RELEASE;
            S_RELEASE: if (!req[grant_id]) state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        busy = state != S_IDLE;
        ack  = (state == S_ACK) ? (N_EVT'(1) << grant_id) : '0;
    end
    assign fire = (state == S_WAIT) && (state_nxt == S_ACK);
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_reg                   <= DLY_W'(ACK_DELAY);
            cnt                         <= '0;
            hold                        <= '0;
            grant_id                    <= '0;
            abort_cnt                   <= '0;
            Initial_ADMA_System_Address <= '0;
        end else begin
            if (cfg_we) delay_reg <= delay_cfg;
            if (state == S_IDLE && |req) begin
                grant_id <= pick;
                cnt      <= delay_reg;
            end
            if (state == S_WAIT && req[grant_id] && cnt != '0) cnt <= cnt - 1'b1;
            if (state == S_WAIT && !req[grant_id] && abort_cnt != 8'hff) abort_cnt <= abort_cnt + 1'b1;
            if (fire) hold <= HW'(ACK_HOLD - 1);
            if (state == S_ACK && hold != '0) hold <= hold - 1'b1;
            // An explicit load overrides the per-descriptor advance on the same edge.
            if (addr_load)
                Initial_ADMA_System_Address <= start_addr;
            else if (fire && grant_id == GW'(ADDR_CH))
                Initial_ADMA_System_Address <= Initial_ADMA_System_Address + ADDR_W'(ADDR_STEP);
        end
    end
endmodule

// File: tb/tb_adma_event_ack.sv
// tb_adma_event_ack: scoreboard bench for adma_event_ack
module tb_adma_event_ack;
    logic        clk = 0, reset = 1, cfg_we = 0, addr_load = 0;
    logic [3:0]  req = 0;
    logic [7:0]  delay_cfg = 0;
    logic [63:0] start_addr = 0;
    logic [3:0]  ack;
    logic [63:0] addr;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  abort_cnt;
    int cyc = 0, vec = 0, errs = 0, exp_abort = 0;
    typedef struct {
        logic [3:0] ack;
        int         cyc;
        logic [1:0] gid;
    } exp_t;
    exp_t q[$];
    adma_event_ack dut (
        .clk(clk), .reset(reset), .req(req), .cfg_we(cfg_we), .delay_cfg(delay_cfg),
        .addr_load(addr_load), .start_addr(start_addr), .ack(ack),
        .Initial_ADMA_System_Address(addr), .busy(busy), .grant_id(grant_id),
        .abort_cnt(abort_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic wait_ack(output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                t = cyc;
                return;
            end
        end
    endtask
    task automatic set_delay(input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1; delay_cfg = d;
        @(negedge clk);
        cfg_we = 0;
    endtask
    task automatic load_addr(input logic [63:0] a);
        @(negedge clk);
        addr_load = 1; start_addr = a;
        @(negedge clk);
        addr_load = 0;
    endtask
    task automatic test_reset;
        reset = 1;
        repeat (2) @(negedge clk);
        vec++; if (ack !== 4'h0) begin errs++; $display("FAIL reset_ack got %h want 0", ack); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL reset_gid got %0d want 0", grant_id); end
        vec++; if (abort_cnt !== 8'd0) begin errs++; $display("FAIL reset_abort got %0d want 0", abort_cnt); end
        vec++; if (addr !== 64'd0) begin errs++; $display("FAIL reset_addr got %h want 0", addr); end
        reset = 0;
    endtask
    task automatic test_basic;
        int t, e0;
        exp_t e;
        @(negedge clk);
        req = 4'b0100; e0 = cyc + 1;
        q.push_back(exp_t'{4'b0100, e0 + 5, 2'd2});
        wait_ack(t);
        e = q.pop_front();
        vec++; if (ack !== e.ack) begin errs++; $display("FAIL basic_ack got %b want %b", ack, e.ack); end
        vec++; if (t !== e.cyc) begin errs++; $display("FAIL basic_lat got %0d want %0d", t, e.cyc); end
        vec++; if (grant_id !== e.gid) begin errs++; $display("FAIL basic_gid got %0d want %0d", grant_id, e.gid); end
        @(negedge clk);
        vec++; if (ack !== 4'b0100) begin errs++; $display("FAIL basic_hold got %b want 0100", ack); end
        @(negedge clk);
        vec++; if (ack !== 4'b0000) begin errs++; $display("FAIL basic_drop got %b want 0000", ack); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_release_busy got %b want 1", busy); end
        req = 0;
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_idle got %b want 0", busy); end
    endtask
    task automatic test_priority;
        int t, e0;
        exp_t e;
        load_addr(64'h1000);
        req = 4'b1001; e0 = cyc + 1;
        q.push_back(exp_t'{4'b0001, e0 + 5, 2'd0});
        wait_ack(t);
        e = q.pop_front();
        vec++; if (ack !== e.ack) begin errs++; $display("FAIL prio_ack0 got %b want %b", ack, e.ack); end
        vec++; if (t !== e.cyc) begin errs++; $display("FAIL prio_lat0 got %0d want %0d", t, e.cyc); end
        repeat (2) @(negedge clk);
        vec++; if (ack !== 4'b0000 || busy !== 1'b1) begin errs++; $display("FAIL prio_release got ack=%b busy=%b want 0000/1", ack, busy); end
        req = 4'b1000;
        q.push_back(exp_t'{4'b1000, cyc + 7, 2'd3});
        wait_ack(t);
        e = q.pop_front();
        vec++; if (ack !== e.ack) begin errs++; $display("FAIL prio_ack3 got %b want %b", ack, e.ack); end
        vec++; if (t !== e.cyc) begin errs++; $display("FAIL prio_lat3 got %0d want %0d", t, e.cyc); end
        vec++; if (grant_id !== e.gid) begin errs++; $display("FAIL prio_gid3 got %0d want %0d", grant_id, e.gid); end
        vec++; if (addr !== 64'h1008) begin errs++; $display("FAIL prio_addr got %h want 1008", addr); end
        req = 0;
        repeat (4) @(negedge clk);
    endtask
    task automatic test_cfg0;
        int t, e0;
        exp_t e;
        set_delay(8'd0);
        req = 4'b0010; e0 = cyc + 1;
        q.push_back(exp_t'{4'b0010, e0 + 1, 2'd1});
        wait_ack(t);
        e = q.pop_front();
        vec++; if (ack !== e.ack) begin errs++; $display("FAIL cfg0_ack got %b want %b", ack, e.ack); end
        vec++; if (t !== e.cyc) begin errs++; $display("FAIL cfg0_lat got %0d want %0d", t, e.cyc); end
        req = 0;
        repeat (4) @(negedge clk);
    endtask
    task automatic test_abort;
        logic [3:0] seen;
        set_delay(8'd10);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        vec++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errs++; $display("FAIL abort_wait got busy=%b gid=%0d want 1/2", busy, grant_id); end
        req = 0; exp_abort++;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen |= ack;
        end
        vec++; if (seen !== 4'b0) begin errs++; $display("FAIL abort_noack got %b want 0000", seen); end
        vec++; if (abort_cnt !== 8'(exp_abort)) begin errs++; $display("FAIL abort_cnt got %0d want %0d", abort_cnt, exp_abort); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_idle got %b want 0", busy); end
    endtask
    task automatic test_wrap;
        int t, e0;
        exp_t e;
        set_delay(8'd4);
        load_addr(64'hFFFF_FFFF_FFFF_FFF8);
        req = 4'b1000; e0 = cyc + 1;
        q.push_back(exp_t'{4'b1000, e0 + 5, 2'd3});
        wait_ack(t);
        e = q.pop_front();
        vec++; if (ack !== e.ack) begin errs++; $display("FAIL wrap_ack got %b want %b", ack, e.ack); end
        vec++; if (t !== e.cyc) begin errs++; $display("FAIL wrap_lat got %0d want %0d", t, e.cyc); end
        vec++; if (addr !== 64'd0) begin errs++; $display("FAIL wrap_addr got %h want 0", addr); end
        req = 0;
        repeat (4) @(negedge clk);
    endtask
    task automatic test_load_then_reset;
        int c;
        exp_t e;
        @(negedge clk);
        req = 4'b1000; c = cyc;
        q.push_back(exp_t'{4'b1000, c + 6, 2'd3});
        repeat (5) @(negedge clk);
        addr_load = 1; start_addr = 64'h2000;
        @(negedge clk);
        addr_load = 0;
        e = q.pop_front();
        vec++; if (ack !== e.ack || cyc !== e.cyc) begin errs++; $display("FAIL load_ack got %b@%0d want %b@%0d", ack, cyc, e.ack, e.cyc); end
        vec++; if (addr !== 64'h2000) begin errs++; $display("FAIL load_wins got %h want 2000", addr); end
        reset = 1;
        @(negedge clk);
        vec++; if (ack !== 4'b0) begin errs++; $display("FAIL midreset_ack got %b want 0000", ack); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL midreset_busy got %b want 0", busy); end
        vec++; if (addr !== 64'd0) begin errs++; $display("FAIL midreset_addr got %h want 0", addr); end
        vec++; if (abort_cnt !== 8'd0) begin errs++; $display("FAIL midreset_abort got %0d want 0", abort_cnt); end
        reset = 0; req = 0;
        @(negedge clk);
    endtask
    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_cfg0;
        test_abort;
        test_wrap;
        test_load_then_reset;
        vec++; if (q.size() != 0) begin errs++; $display("FAIL scoreboard_left got %0d want 0", q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
